// File: rtl/kmap_sweep_ctrl_if.sv
// Bundle between the lab top-level / function under test and the K-map sweep sequencer.
// The master side drives start/abort/expected and the function unit output.
// The slave side is the sequencer itself.
interface kmap_sweep_ctrl_if #(
    parameter int unsigned N_IN = 4
);
    localparam int unsigned NCodes = 2 ** N_IN;

    logic              start;
    logic              abort;
    logic [NCodes-1:0] expected;
    logic [N_IN-1:0]   fn_in;
    logic              fn_out;
    logic              busy;
    logic              done;
    logic              result_valid;
    logic [NCodes-1:0] truth_table;
    logic              match;
    logic [N_IN:0]     mismatch_count;
    logic [N_IN-1:0]   first_fail;

    modport master (
        output start, abort, expected, fn_out,
        input  fn_in, busy, done, result_valid, truth_table, match, mismatch_count, first_fail
    );

    modport slave (
        input  start, abort, expected, fn_out,
        output fn_in, busy, done, result_valid, truth_table, match, mismatch_count, first_fail
    );
endinterface

// File: rtl/kmap_sweep_ctrl.sv
// Exhaustive sweep sequencer for an N_IN-input combinational function unit.
// Each code is driven, held for SETTLE cycles and then sampled.
// The captured truth table is compared against an expected mask latched at start.
module kmap_sweep_ctrl #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1   // 0..15
) (
    input logic              clk,
    input logic              rst_n,
    kmap_sweep_ctrl_if.slave bus
);
    localparam int unsigned     NCodes     = 2 ** N_IN;
    localparam int unsigned     SettleLast = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [N_IN-1:0] LastCode   = {N_IN{1'b1}};

    typedef enum logic [1:0] {StIdle, StApply, StSample, StFinish} state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   code_q, code_d;
    logic [3:0]        settle_q, settle_d;
    logic [NCodes-1:0] exp_q, exp_d;
    logic [NCodes-1:0] tt_q, tt_d;
    logic [N_IN:0]     miss_q, miss_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              valid_q, valid_d;
    logic              match_q, match_d;
    logic              busy;

    // State and result registers; reset clears everything, including mid-sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            code_q   <= '0;
            settle_q <= '0;
            exp_q    <= '0;
            tt_q     <= '0;
            miss_q   <= '0;
            ff_q     <= '0;
            valid_q  <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            settle_q <= settle_d;
            exp_q    <= exp_d;
            tt_q     <= tt_d;
            miss_q   <= miss_d;
            ff_q     <= ff_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
        end
    end

    // Next-state and datapath update for the sweep.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        tt_d     = tt_q;
        miss_d   = miss_q;
        ff_d     = ff_q;
        valid_d  = valid_q;
        match_d  = match_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    exp_d    = bus.expected;
                    code_d   = '0;
                    settle_d = '0;
                    tt_d     = '0;
                    miss_d   = '0;
                    ff_d     = '0;
                    valid_d  = 1'b0;
                    match_d  = 1'b0;
                    // With no settle time every code lives in SAMPLE alone.
                    state_d  = (SETTLE == 0) ? StSample : StApply;
                end
            end

            StApply: begin
                if (bus.abort) begin
                    state_d  = StIdle;
                    code_d   = '0;
                    settle_d = '0;
                end else if (settle_q == 4'(SettleLast)) begin
                    settle_d = '0;
                    state_d  = StSample;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            StSample: begin
                if (bus.abort) begin
                    // Abort beats the sample; partial table stays visible.
                    state_d = StIdle;
                    code_d  = '0;
                end else begin
                    tt_d[code_q] = bus.fn_out;
                    if (bus.fn_out != exp_q[code_q]) begin
                        miss_d = miss_q + 1'b1;
                        if (miss_q == '0) begin
                            ff_d = code_q;
                        end
                    end
                    // Final code detected explicitly so the counter never wraps.
                    if (code_q == LastCode) begin
                        state_d = StFinish;
                        code_d  = '0;
                        valid_d = 1'b1;
                        match_d = (miss_d == '0);
                    end else begin
                        code_d  = code_q + 1'b1;
                        state_d = (SETTLE == 0) ? StSample : StApply;
                    end
                end
            end

            StFinish: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q == StApply) || (state_q == StSample);

    assign bus.busy           = busy;
    assign bus.fn_in          = busy ? code_q : '0;
    assign bus.done           = (state_q == StFinish);
    assign bus.result_valid   = valid_q;
    assign bus.truth_table    = tt_q;
    assign bus.match          = match_q;
    assign bus.mismatch_count = miss_q;
    assign bus.first_fail     = ff_q;
endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Directed bench for kmap_sweep_ctrl: one SETTLE=1 instance and one SETTLE=0 instance
// driving a model of the minimised SOP f = sum m(0,1,2,8,9,12,15).
module tb_kmap_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic stuck0 = 1'b0;

    always #5 clk = ~clk;

    kmap_sweep_ctrl_if #(.N_IN(4)) bus  ();
    kmap_sweep_ctrl_if #(.N_IN(4)) bus0 ();

    kmap_sweep_ctrl #(.N_IN(4), .SETTLE(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    kmap_sweep_ctrl #(.N_IN(4), .SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    function automatic logic sop(input logic [3:0] x);
        return (x == 4'd0) || (x == 4'd1) || (x == 4'd2) || (x == 4'd8) ||
               (x == 4'd9) || (x == 4'd12) || (x == 4'd15);
    endfunction

    assign bus.fn_out  = stuck0 ? 1'b0 : sop(bus.fn_in);
    assign bus0.fn_out = sop(bus0.fn_in);

    typedef struct {
        logic [15:0] tt;
        logic        match;
        logic [4:0]  cnt;
        logic [3:0]  ff;
        int          len;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    function automatic exp_t model(input logic [15:0] m, input logic stuck, input int settle);
        exp_t        e;
        logic [15:0] tt;
        logic [15:0] diff;
        for (int k = 0; k < 16; k++) tt[k] = stuck ? 1'b0 : sop(4'(k));
        diff = tt ^ m;
        e.tt = tt;
        e.cnt = 5'($countones(diff));
        e.ff = '0;
        for (int k = 15; k >= 0; k--) if (diff[k]) e.ff = 4'(k);
        e.match = (diff == 16'h0);
        e.len = 16 * (settle + 1);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One sweep on the SETTLE=1 instance, with optional abort and stray start pulses.
    task automatic sweep(input logic [15:0] m, input logic stuck, input int abort_at,
                         input int extra_a, input int extra_b);
        exp_t e;
        int   n = 0;
        int   dones = 0;
        int   fn_err = 0;
        int   post = 0;
        bit   aborted = 1'b0;
        @(negedge clk);
        stuck0 = stuck;
        bus.expected = m;
        bus.start = 1'b1;
        if (abort_at == 0) sb.push_back(model(m, stuck, 1));
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (aborted) begin
                post++;
                if (post == 1) begin
                    chk("abort_busy_drop", 32'(bus.busy), 32'd0);
                    chk("abort_fn_in_zero", 32'(bus.fn_in), 32'd0);
                end
                if (post == 4) break;
            end
            if (bus.busy) begin
                n++;
                if (bus.fn_in !== 4'((n - 1) / 2)) fn_err++;
                if (n == extra_a || n == extra_b) bus.start = 1'b1;
                if (n == abort_at) begin
                    bus.abort = 1'b1;
                    aborted = 1'b1;
                end
            end
            if (bus.done) begin
                dones++;
                break;
            end
        end
        chk("fn_in_sequence_errors", 32'(fn_err), 32'd0);
        if (abort_at > 0) begin
            chk("abort_no_done", 32'(dones), 32'd0);
            chk("abort_result_valid", 32'(bus.result_valid), 32'd0);
            chk("abort_partial_tt", 32'(bus.truth_table),
                32'(model(m, stuck, 1).tt & 16'((1 << ((abort_at - 1) / 2)) - 1)));
        end else begin
            chk("done_seen", 32'(dones), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("busy_length", 32'(n), 32'(e.len));
                chk("finish_busy_low", 32'(bus.busy), 32'd0);
                chk("finish_result_valid", 32'(bus.result_valid), 32'd1);
                chk("truth_table", 32'(bus.truth_table), 32'(e.tt));
                chk("match", 32'(bus.match), 32'(e.match));
                chk("mismatch_count", 32'(bus.mismatch_count), 32'(e.cnt));
                chk("first_fail", 32'(bus.first_fail), 32'(e.ff));
                @(negedge clk);
                chk("done_single_pulse", 32'(bus.done), 32'd0);
                chk("results_hold_valid", 32'(bus.result_valid), 32'd1);
                chk("results_hold_tt", 32'(bus.truth_table), 32'(e.tt));
            end
        end
    endtask

    initial begin
        exp_t e;
        int   n;
        int   dones;
        int   fn_err;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.expected = '0;
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        bus0.expected = '0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_fn_in", 32'(bus.fn_in), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_match", 32'(bus.match), 32'd0);
        chk("rst_truth_table", 32'(bus.truth_table), 32'd0);
        chk("rst_mismatch_count", 32'(bus.mismatch_count), 32'd0);
        chk("rst_first_fail", 32'(bus.first_fail), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        sweep(16'h9307, 1'b0, 0, 0, 0);    // correct K-map
        sweep(16'h9306, 1'b0, 0, 0, 0);    // one wrong bit
        sweep(16'h9307, 1'b1, 0, 0, 0);    // stuck-at-0 unit
        sweep(16'h9307, 1'b0, 10, 0, 0);   // abort at busy cycle 10
        sweep(16'h9307, 1'b0, 0, 0, 0);    // restart from code 0 after abort
        sweep(16'h9306, 1'b0, 0, 5, 20);   // stray starts while busy

        // abort while idle leaves the held results alone
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("idle_abort_valid", 32'(bus.result_valid), 32'd1);
        chk("idle_abort_busy", 32'(bus.busy), 32'd0);

        // SETTLE=0 instance: one cycle per code
        @(negedge clk);
        bus0.expected = 16'h9307;
        bus0.start = 1'b1;
        sb.push_back(model(16'h9307, 1'b0, 0));
        n = 0;
        dones = 0;
        fn_err = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus0.start = 1'b0;
            if (bus0.busy) begin
                n++;
                if (bus0.fn_in !== 4'(n - 1)) fn_err++;
            end
            if (bus0.done) begin
                dones++;
                break;
            end
        end
        e = sb.pop_front();
        chk("s0_done_seen", 32'(dones), 32'd1);
        chk("s0_busy_length", 32'(n), 32'(e.len));
        chk("s0_fn_in_sequence_errors", 32'(fn_err), 32'd0);
        chk("s0_truth_table", 32'(bus0.truth_table), 32'(e.tt));
        chk("s0_match", 32'(bus0.match), 32'(e.match));

        // Reset dropped mid-sweep, between clock edges
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("s0_mid_busy", 32'(bus0.busy), 32'd1);
        chk("s0_mid_tt_nonzero", 32'(bus0.truth_table != 16'h0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s0_arst_busy", 32'(bus0.busy), 32'd0);
        chk("s0_arst_fn_in", 32'(bus0.fn_in), 32'd0);
        chk("s0_arst_result_valid", 32'(bus0.result_valid), 32'd0);
        chk("s0_arst_match", 32'(bus0.match), 32'd0);
        chk("s0_arst_truth_table", 32'(bus0.truth_table), 32'd0);
        chk("s0_arst_mismatch_count", 32'(bus0.mismatch_count), 32'd0);
        chk("arst_result_valid", 32'(bus.result_valid), 32'd0);
        chk("arst_truth_table", 32'(bus.truth_table), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
